intersection_controller: RTL and testbench
==========================================

# intersection_controller

Sequencer for a two-approach intersection: it drives a main-street and a side-street signal head, each using the team's standard 3-bit `leds` encoding. Main street rests in green. A latched side-street demand triggers a timed yellow → all-red → side green → side yellow → all-red cycle. All timing counts a 1-per-second `tick` enable, so the block runs on the system clock without a divided clock. It sits above the per-head lamp drivers and is the only source of their state.

## Interface

Parameters:
- `MAIN_MIN`, 30: minimum main-green duration, ticks (≥1)
- `SIDE_GREEN`, 10: side-green duration, ticks (≥1)
- `YELLOW`, 3: yellow duration for either head, ticks (≥1)
- `ALL_RED`, 2: all-red clearance duration, ticks (≥1)
- `TW`, 5: timer width; every duration must be ≤ 2^TW

Ports:
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous reset, active-low. Fixed decision: one clock; reset is asynchronous and active-low.
- `tick` input 1: one-`clk`-wide timing strobe.
- `side_req` input 1: side-street demand, level, sampled every `clk`.
- `main_leds` output [0:2]: main head; 100 = green, 010 = yellow, 001 = red.
- `side_leds` output [0:2]: side head; same encoding.
- `side_walk` output 1: pedestrian walk lamp, high only in S_GREEN.
- `phase` output [2:0]: current state code, for debug and status.
- `req_pending` output 1: latched demand.

## Operation

States and `phase` codes:
- INIT_RED (0): both heads 001. After ALL_RED ticks, go to M_GREEN.
- M_GREEN (1): main 100, side 001.
- M_YELLOW (2): main 010, side 001. After YELLOW ticks, go to CLR1.
- CLR1 (3): both heads 001. After ALL_RED ticks, go to S_GREEN.
- S_GREEN (4): main 001, side 100, `side_walk` = 1. After SIDE_GREEN ticks, go to S_YELLOW.
- S_YELLOW (5): main 001, side 010. After YELLOW ticks, go to CLR2.
- CLR2 (6): both heads 001. After ALL_RED ticks, go to M_GREEN.

Timer rules:
- `timer` is TW bits and clears to 0 on every state entry.
- On a `tick` cycle in a timed state: if `timer == DUR-1`, advance to the next state; otherwise increment `timer`.
- So each timed state spans exactly DUR ticks.
- Timer arithmetic is unsigned and never wraps.

M_GREEN rules:
- On a `tick` cycle:
  - If `timer == MAIN_MIN-1` and `req_pending` = 1, go to M_YELLOW.
  - Else, if `timer < MAIN_MIN-1`, increment `timer`.
  - Else hold `timer` at MAIN_MIN-1.
- Main therefore dwells in green indefinitely when there is no demand.
- Once the minimum has elapsed, demand is served on the next tick.

Request latch:
- `req_pending` sets on any cycle with `side_req` = 1.
- It clears on the cycle the state enters S_GREEN.
- Clear wins over set on that cycle.
- Demand asserted during S_GREEN, S_YELLOW or CLR2 sets the latch again and is served after the next full MAIN_MIN.

Other rules:
- `tick` low means no timer or state change. Only the latch updates.
- Illegal state codes return to INIT_RED on the next `clk`.
- There is never a cycle where both heads show non-red.

## Timing

- `phase`, `timer` and `req_pending` are registers.
- `main_leds`, `side_leds`, `side_walk` and `phase` decode from the state register, Moore style. They change in the same cycle the state register updates: one `clk` after the deciding `tick`.
- Reset values on `rst` = 0, immediate, asynchronous:
  - state INIT_RED, `phase` = 0, `timer` = 0, `req_pending` = 0
  - `main_leds` = 001, `side_leds` = 001, `side_walk` = 0
- Release of `rst` is synchronous to `clk`. The first tick counts toward INIT_RED.
- Reset mid-cycle, in any state, forces all-red at once and restarts from INIT_RED. A pending request is discarded.
- `side_req` to `req_pending` latency: one `clk`.
- With `req_pending` already set, the worst-case time from M_GREEN entry to S_GREEN entry is MAIN_MIN + YELLOW + ALL_RED ticks.

## Test plan

- **Reset:** assert `rst` = 0 mid-S_GREEN → both heads 001, `side_walk` 0, `phase` 0, `req_pending` 0 in the same cycle; after release + 2 ticks → `phase` 1, main 100.
- **No demand:** hold `side_req` = 0 for 200 ticks after M_GREEN entry → `main_leds` stays 100 and `phase` stays 1 throughout.
- **Full cycle, defaults:** pulse `side_req` for one `clk` at tick 5 of M_GREEN. Required response:
  - main 010 at tick 30
  - all-red at tick 33
  - side 100 and `side_walk` 1 at tick 35
  - side 010 at tick 45
  - all-red at tick 48
  - main 100 at tick 50
- **Late demand:** assert `side_req` at tick 40 of M_GREEN → M_YELLOW entered on the next tick (tick 41); `req_pending` clears on S_GREEN entry.
- **Re-request:** pulse `side_req` during S_YELLOW → `req_pending` = 1 through CLR2; main green lasts exactly 30 ticks, then yellow.
- **Tick gating and overlap:** hold `tick` low for 1000 `clk` in every state → no state change. A checker asserts on every cycle that `main_leds` and `side_leds` are never both non-001.

Source files
------------

// File: rtl/intersection_controller.sv
// Two-approach intersection sequencer: main street rests green, a latched side
// demand runs yellow -> all-red -> side green -> side yellow -> all-red, timed by 'tick'.
module intersection_controller #(
    parameter int MAIN_MIN   = 30,
    parameter int SIDE_GREEN = 10,
    parameter int YELLOW     = 3,
    parameter int ALL_RED    = 2,
    parameter int TW         = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       side_req,
    output logic [0:2] main_leds,
    output logic [0:2] side_leds,
    output logic       side_walk,
    output logic [2:0] phase,
    output logic       req_pending
);

    typedef enum logic [2:0] {
        INIT_RED = 3'd0,
        M_GREEN  = 3'd1,
        M_YELLOW = 3'd2,
        CLR1     = 3'd3,
        S_GREEN  = 3'd4,
        S_YELLOW = 3'd5,
        CLR2     = 3'd6
    } state_e;

    localparam logic [TW-1:0] MAIN_LAST   = TW'(MAIN_MIN - 1);
    localparam logic [TW-1:0] SIDE_LAST   = TW'(SIDE_GREEN - 1);
    localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW - 1);
    localparam logic [TW-1:0] CLEAR_LAST  = TW'(ALL_RED - 1);

    localparam logic [0:2] LED_GREEN  = 3'b100;
    localparam logic [0:2] LED_YELLOW = 3'b010;
    localparam logic [0:2] LED_RED    = 3'b001;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          req_q, req_d;

    logic [TW-1:0] last;
    state_e        next_state;
    logic          illegal;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        last       = '0;
        next_state = INIT_RED;
        illegal    = 1'b0;

        case (state_q)
            INIT_RED: begin last = CLEAR_LAST;  next_state = M_GREEN;  end
            M_GREEN:  begin last = MAIN_LAST;   next_state = M_YELLOW; end
            M_YELLOW: begin last = YELLOW_LAST; next_state = CLR1;     end
            CLR1:     begin last = CLEAR_LAST;  next_state = S_GREEN;  end
            S_GREEN:  begin last = SIDE_LAST;   next_state = S_YELLOW; end
            S_YELLOW: begin last = YELLOW_LAST; next_state = CLR2;     end
            CLR2:     begin last = CLEAR_LAST;  next_state = M_GREEN;  end
            default:  illegal = 1'b1;
        endcase

        if (illegal) begin
            state_d = INIT_RED;
            timer_d = '0;
        end else if (tick) begin
            if (state_q == M_GREEN) begin
                // Main green saturates at its minimum and waits there for demand.
                if (timer_q == last && req_q) begin
                    state_d = next_state;
                    timer_d = '0;
                end else if (timer_q < last) begin
                    timer_d = timer_q + 1'b1;
                end
            end else if (timer_q == last) begin
                state_d = next_state;
                timer_d = '0;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end

        // Entry into side green consumes the demand; that clear beats a same-cycle set.
        req_d = (req_q | side_req) & ~(state_d == S_GREEN && state_q != S_GREEN);
    end

    // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT_RED;
            timer_q <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        main_leds = LED_RED;
        side_leds = LED_RED;
        side_walk = 1'b0;
        case (state_q)
            M_GREEN:  main_leds = LED_GREEN;
            M_YELLOW: main_leds = LED_YELLOW;
            S_GREEN:  begin side_leds = LED_GREEN; side_walk = 1'b1; end
            S_YELLOW: side_leds = LED_YELLOW;
            default:  ;
        endcase
    end

    assign phase       = state_q;
    assign req_pending = req_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Bench for intersection_controller: a tick-counting phase model checked every cycle,
// directed walks through the signal cycle with literal expectations, then random traffic.
module tb_intersection_controller;

    localparam int MAIN_MIN = 30;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       side_req;
    logic [0:2] main_leds;
    logic [0:2] side_leds;
    logic       side_walk;
    logic [2:0] phase;
    logic       req_pending;

    int n_cmp = 0;
    int n_err = 0;

    intersection_controller dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .side_req   (side_req),
        .main_leds  (main_leds),
        .side_leds  (side_leds),
        .side_walk  (side_walk),
        .phase      (phase),
        .req_pending(req_pending)
    );

    always #5 clk = ~clk;

    // Phase-indexed tables: how many ticks each phase lasts, what follows, and the lamps shown.
    int         dur_t  [7] = '{2, MAIN_MIN, 3, 2, 10, 3, 2};
    int         next_t [7] = '{1, 2, 3, 4, 5, 6, 1};
    logic [2:0] main_t [7] = '{3'b001, 3'b100, 3'b010, 3'b001, 3'b001, 3'b001, 3'b001};
    logic [2:0] side_t [7] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b100, 3'b010, 3'b001};

    int m_phase = 0;
    int m_k     = 0;
    bit m_req   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: count ticks since phase entry; main green leaves once MAIN_MIN ticks are in and demand is held.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase <= 0;
            m_k     <= 0;
            m_req   <= 1'b0;
        end else if (tick && (m_phase == 1 ? (m_k + 1 >= MAIN_MIN && m_req)
                                           : (m_k + 1 == dur_t[m_phase]))) begin
            m_phase <= next_t[m_phase];
            m_k     <= 0;
            m_req   <= (m_req || side_req) && (next_t[m_phase] != 4);
        end else begin
            if (tick) m_k <= m_k + 1;
            m_req <= m_req || side_req;
        end
    end

    always @(negedge clk) begin
        check("phase",      32'(phase),       32'(m_phase));
        check("main_leds",  32'(main_leds),   32'(main_t[m_phase]));
        check("side_leds",  32'(side_leds),   32'(side_t[m_phase]));
        check("side_walk",  32'(side_walk),   32'(m_phase == 4));
        check("req",        32'(req_pending), 32'(m_req));
        check("no_overlap", 32'(!(main_leds != 3'b001 && side_leds != 3'b001)), 32'd1);
    end

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic pulse_req();
        side_req = 1'b1;
        @(negedge clk);
        side_req = 1'b0;
    endtask

    task automatic hold(input int exp_phase, input string name);
        tick = 1'b0;
        repeat (1000) @(negedge clk);
        check(name, 32'(phase), 32'(exp_phase));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        tick     = 1'b0;
        side_req = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_phase", 32'(phase),       32'd0);
        check("rst_main",  32'(main_leds),   32'b001);
        check("rst_side",  32'(side_leds),   32'b001);
        check("rst_walk",  32'(side_walk),   32'd0);
        check("rst_req",   32'(req_pending), 32'd0);

        rst = 1'b1;
        ticks(1);
        check("init_1tick", 32'(phase), 32'd0);
        ticks(1);
        check("init_done_phase", 32'(phase),     32'd1);
        check("init_done_main",  32'(main_leds), 32'b100);

        // Full cycle with defaults, demand at tick 5 of main green.
        ticks(5);
        pulse_req();
        check("req_latency", 32'(req_pending), 32'd1);
        ticks(24);
        check("t29_still_green", 32'(phase), 32'd1);
        ticks(1);
        check("t30_main_yellow", 32'(main_leds), 32'b010);
        ticks(3);
        check("t33_allred_main", 32'(main_leds), 32'b001);
        check("t33_allred_side", 32'(side_leds), 32'b001);
        ticks(2);
        check("t35_side_green", 32'(side_leds),   32'b100);
        check("t35_walk",       32'(side_walk),   32'd1);
        check("t35_req_clear",  32'(req_pending), 32'd0);
        ticks(10);
        check("t45_side_yellow", 32'(side_leds), 32'b010);
        pulse_req();
        ticks(3);
        check("t48_allred", 32'(phase),       32'd6);
        check("t48_req",    32'(req_pending), 32'd1);
        ticks(2);
        check("t50_main_green", 32'(main_leds), 32'b100);

        // Re-request: main green lasts exactly MAIN_MIN ticks.
        ticks(29);
        check("rereq_t29", 32'(phase), 32'd1);
        ticks(1);
        check("rereq_t30", 32'(main_leds), 32'b010);
        ticks(5);
        check("rereq_sgreen", 32'(phase), 32'd4);
        ticks(15);
        check("back_to_main", 32'(phase), 32'd1);

        // No demand: rest in main green.
        ticks(200);
        check("nodemand_phase", 32'(phase),     32'd1);
        check("nodemand_main",  32'(main_leds), 32'b100);
        pulse_req();
        ticks(1);
        check("served_next_tick", 32'(phase), 32'd2);
        ticks(5);
        ticks(15);
        check("fresh_main", 32'(phase), 32'd1);

        // Late demand at tick 40.
        ticks(40);
        pulse_req();
        ticks(1);
        check("late_yellow", 32'(phase), 32'd2);

        // Tick gating in every state.
        hold(2, "hold_m_yellow");
        ticks(3);  hold(3, "hold_clr1");
        ticks(2);  hold(4, "hold_s_green");
        check("late_req_cleared", 32'(req_pending), 32'd0);
        ticks(10); hold(5, "hold_s_yellow");
        ticks(3);  hold(6, "hold_clr2");
        ticks(2);  hold(1, "hold_m_green");

        // Reset in the middle of side green with a demand pending.
        pulse_req();
        ticks(30);
        ticks(5);
        ticks(3);
        pulse_req();
        check("pre_reset_phase", 32'(phase), 32'd4);
        #2 rst = 1'b0;
        #1;
        check("midrst_phase", 32'(phase),       32'd0);
        check("midrst_main",  32'(main_leds),   32'b001);
        check("midrst_side",  32'(side_leds),   32'b001);
        check("midrst_walk",  32'(side_walk),   32'd0);
        check("midrst_req",   32'(req_pending), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        hold(0, "hold_init_red");
        ticks(2);
        check("post_rst_phase", 32'(phase),     32'd1);
        check("post_rst_main",  32'(main_leds), 32'b100);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            tick     = ($urandom_range(0, 3) == 0);
            side_req = ($urandom_range(0, 40) == 0);
            if (i == 2000) rst = 1'b0;
            if (i == 2003) rst = 1'b1;
            @(negedge clk);
        end
        tick     = 1'b0;
        side_req = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
